// File: rtl/detect_buf_sched.sv
// Multi-buffer capture/detect scheduler: fills frame buffers, hands them to the classifier in FIFO order.
// Ports: clk, rst (sync, active-high), cap_done, detect_done, continue_req (single-shot arm),
//   cont_mode, write_en_in, wr_addr, classifier_rd_addr -> mem_wr_en, mem_wr_addr,
//   mem_rd_addr, detect_en, detect_start, fill_level, busy.
//   `continue` is a SystemVerilog keyword, so the arm request port is named continue_req.
// Build option: define DROP_COUNT_EN to add the 8-bit saturating frames_dropped counter port.
module detect_buf_sched #(
    parameter int ADDR_W = 15,
    parameter int NBUF   = 2,
    localparam int BUF_W = (NBUF == 4) ? 2 : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_done,
    input  logic                    detect_done,
    input  logic                    continue_req,
    input  logic                    cont_mode,
    input  logic                    write_en_in,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [ADDR_W-1:0]       classifier_rd_addr,
    output logic                    mem_wr_en,
    output logic [ADDR_W+BUF_W-1:0] mem_wr_addr,
    output logic [ADDR_W+BUF_W-1:0] mem_rd_addr,
    output logic                    detect_en,
    output logic                    detect_start,
    output logic [BUF_W:0]          fill_level,
    output logic                    busy
`ifdef DROP_COUNT_EN
    ,
    output logic [7:0]              frames_dropped
`endif
);

    localparam int FW = BUF_W + 1;
    localparam logic [BUF_W:0] FULL = FW'(NBUF);

    typedef enum logic [1:0] {C_IDLE, C_SYNC, C_FILL} cap_state_t;
    typedef enum logic {D_IDLE, D_RUN} det_state_t;

    cap_state_t cstate, cnext;
    det_state_t dstate, dnext;

    logic             cap_done_z;
    logic             rise;
    logic             arm_latched, arm_next;
    logic [BUF_W-1:0] wr_ptr, rd_ptr;
    logic             inc, dec;
    logic             en_next, start_next;
    logic [BUF_W:0]   fill_cand;
    logic [BUF_W:0]   fill_next;

    assign rise = cap_done & ~cap_done_z;

    // Occupancy if the current frame completes this cycle, including a
    // concurrent release by the classifier.
    assign fill_cand = fill_level + FW'(1) - FW'(dec);
    assign fill_next = fill_level + FW'(inc) - FW'(dec);

    assign mem_wr_en   = (cstate == C_FILL) ? write_en_in : 1'b0;
    assign mem_wr_addr = {wr_ptr, wr_addr};
    assign mem_rd_addr = {rd_ptr, classifier_rd_addr};
    assign busy = (cstate != C_IDLE) || (dstate != D_IDLE) || (fill_level != '0);

    // Capture FSM
    always_comb begin
        cnext    = cstate;
        arm_next = arm_latched;
        inc      = 1'b0;
        unique case (cstate)
            C_IDLE: begin
                if (arm_latched || cont_mode) begin
                    cnext    = C_SYNC;
                    arm_next = 1'b0;
                end else if (continue_req) begin
                    arm_next = 1'b1;
                end
            end
            C_SYNC: begin
                if (rise && fill_level < FULL) cnext = C_FILL;
            end
            C_FILL: begin
                if (rise) begin
                    inc = 1'b1;
                    if (!cont_mode)            cnext = C_IDLE;
                    else if (fill_cand < FULL) cnext = C_FILL;
                    else                       cnext = C_SYNC;
                end
            end
            default: cnext = C_IDLE;
        endcase
    end

    // Detect FSM; its outputs are registered from the next-state values
    always_comb begin
        dnext      = dstate;
        dec        = 1'b0;
        en_next    = detect_en;
        start_next = 1'b0;
        unique case (dstate)
            D_IDLE: begin
                if (fill_level != '0) begin
                    dnext      = D_RUN;
                    en_next    = 1'b1;
                    start_next = 1'b1;
                end
            end
            D_RUN: begin
                if (detect_done) begin
                    dnext   = D_IDLE;
                    dec     = 1'b1;
                    en_next = 1'b0;
                end
            end
            default: dnext = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cstate       <= C_IDLE;
            dstate       <= D_IDLE;
            cap_done_z   <= 1'b1;
            arm_latched  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            detect_en    <= 1'b0;
            detect_start <= 1'b0;
        end else begin
            cstate       <= cnext;
            dstate       <= dnext;
            cap_done_z   <= cap_done;
            arm_latched  <= arm_next;
            fill_level   <= fill_next;
            detect_en    <= en_next;
            detect_start <= start_next;
            if (inc) wr_ptr <= wr_ptr + 1'b1;
            if (dec) rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef DROP_COUNT_EN
    // A frame is lost when its start edge finds every buffer occupied
    logic drop;
    assign drop = rise &&
        ((cstate == C_SYNC && fill_level == FULL) ||
         (cstate == C_FILL && cont_mode && fill_cand >= FULL));

    always_ff @(posedge clk) begin
        if (rst)
            frames_dropped <= 8'd0;
        else if (drop && frames_dropped != 8'hFF)
            frames_dropped <= frames_dropped + 8'd1;
    end
`endif

endmodule

// File: tb/tb_detect_buf_sched.sv
// Directed self-checking bench for detect_buf_sched (NBUF=2, ADDR_W=15).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_detect_buf_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_done;
    logic        detect_done;
    logic        continue_req;
    logic        cont_mode;
    logic        write_en_in;
    logic [14:0] wr_addr;
    logic [14:0] classifier_rd_addr;
    logic        mem_wr_en;
    logic [15:0] mem_wr_addr;
    logic [15:0] mem_rd_addr;
    logic        detect_en;
    logic        detect_start;
    logic [1:0]  fill_level;
    logic        busy;
`ifdef DROP_COUNT_EN
    logic [7:0]  frames_dropped;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    detect_buf_sched #(.ADDR_W(15), .NBUF(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .cap_done           (cap_done),
        .detect_done        (detect_done),
        .continue_req       (continue_req),
        .cont_mode          (cont_mode),
        .write_en_in        (write_en_in),
        .wr_addr            (wr_addr),
        .classifier_rd_addr (classifier_rd_addr),
        .mem_wr_en          (mem_wr_en),
        .mem_wr_addr        (mem_wr_addr),
        .mem_rd_addr        (mem_rd_addr),
        .detect_en          (detect_en),
        .detect_start       (detect_start),
        .fill_level         (fill_level),
        .busy               (busy)
`ifdef DROP_COUNT_EN
        ,
        .frames_dropped     (frames_dropped)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        cap_done = 1'b0;
        detect_done = 1'b0;
        continue_req = 1'b0;
        cont_mode = 1'b0;
        write_en_in = 1'b1;
        wr_addr = 15'h0;
        classifier_rd_addr = 15'h5;
        tick();
        tick();

        // reset state
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_den", 32'(detect_en), 32'd0);
        chk("rst_dstart", 32'(detect_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wren", 32'(mem_wr_en), 32'd0);
`ifdef DROP_COUNT_EN
        chk("rst_drop", 32'(frames_dropped), 32'd0);
`endif

        // single shot
        rst = 1'b0;
        write_en_in = 1'b0;
        tick();
        continue_req = 1'b1;
        tick();
        continue_req = 1'b0;
        tick();
        write_en_in = 1'b1;
        #1;
        chk("sync_busy", 32'(busy), 32'd1);
        chk("sync_wren", 32'(mem_wr_en), 32'd0);
        cap_done = 1'b1;
        tick();
        wr_addr = 15'h123;
        #1;
        chk("fill_wren", 32'(mem_wr_en), 32'd1);
        chk("fill_wraddr", 32'(mem_wr_addr), 32'h0123);
        chk("fill_rdaddr", 32'(mem_rd_addr), 32'h0005);
        cap_done = 1'b0;
        tick();
        cap_done = 1'b1;
        tick();
        chk("ss_fill1", 32'(fill_level), 32'd1);
        chk("ss_den_lat", 32'(detect_en), 32'd0);
        chk("ss_idle_wren", 32'(mem_wr_en), 32'd0);
        tick();
        chk("ss_den", 32'(detect_en), 32'd1);
        chk("ss_dstart", 32'(detect_start), 32'd1);
        tick();
        wr_addr = 15'h0;
        #1;
        chk("ss_dstart_off", 32'(detect_start), 32'd0);
        chk("ss_den_hold", 32'(detect_en), 32'd1);
        chk("ss_wrptr1", 32'(mem_wr_addr), 32'h8000);
        detect_done = 1'b1;
        tick();
        detect_done = 1'b0;
        chk("ss_fill0", 32'(fill_level), 32'd0);
        chk("ss_den_off", 32'(detect_en), 32'd0);
        chk("ss_rdptr1", 32'(mem_rd_addr), 32'h8005);
        chk("ss_busy0", 32'(busy), 32'd0);

        // cap_done held high through reset, continuous mode
        rst = 1'b1;
        cont_mode = 1'b1;
        wr_addr = 15'h7;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("hold_nofill", 32'(mem_wr_en), 32'd0);
        chk("hold_fill0", 32'(fill_level), 32'd0);
        cap_done = 1'b0;
        tick();
        cap_done = 1'b1;
        tick();
        chk("cm_f1_wren", 32'(mem_wr_en), 32'd1);
        chk("cm_f1_addr", 32'(mem_wr_addr), 32'h0007);
        cap_done = 1'b0;
        tick();
        cap_done = 1'b1;
        tick();
        chk("cm_f2_fill", 32'(fill_level), 32'd1);
        chk("cm_f2_wren", 32'(mem_wr_en), 32'd1);
        chk("cm_f2_addr", 32'(mem_wr_addr), 32'h8007);
        cap_done = 1'b0;
        tick();
        chk("cm_dstart", 32'(detect_start), 32'd1);
        cap_done = 1'b1;
        tick();
        chk("cm_f3_fill", 32'(fill_level), 32'd2);
        chk("cm_f3_wren", 32'(mem_wr_en), 32'd0);
`ifdef DROP_COUNT_EN
        chk("cm_drop1", 32'(frames_dropped), 32'd1);
`endif
        cap_done = 1'b0;
        tick();
        cap_done = 1'b1;
        tick();
        chk("cm_f4_fill", 32'(fill_level), 32'd2);
        chk("cm_f4_wren", 32'(mem_wr_en), 32'd0);
`ifdef DROP_COUNT_EN
        chk("cm_drop2", 32'(frames_dropped), 32'd2);
`endif

        // release one buffer, then a completing rise with detect_done
        cap_done = 1'b0;
        detect_done = 1'b1;
        tick();
        detect_done = 1'b0;
        chk("rel_fill", 32'(fill_level), 32'd1);
        chk("rel_den", 32'(detect_en), 32'd0);
        chk("rel_rdaddr", 32'(mem_rd_addr), 32'h8005);
        cap_done = 1'b1;
        tick();
        chk("rel_dstart", 32'(detect_start), 32'd1);
        chk("rel_wren", 32'(mem_wr_en), 32'd1);
        chk("rel_wraddr", 32'(mem_wr_addr), 32'h0007);
        cap_done = 1'b0;
        tick();
        cap_done = 1'b1;
        detect_done = 1'b1;
        tick();
        detect_done = 1'b0;
        chk("sim_fill", 32'(fill_level), 32'd1);
        chk("sim_den", 32'(detect_en), 32'd0);
        chk("sim_rdaddr", 32'(mem_rd_addr), 32'h0005);
        chk("sim_wraddr", 32'(mem_wr_addr), 32'h8007);
        chk("sim_wren", 32'(mem_wr_en), 32'd1);
        tick();
        chk("sim_den2", 32'(detect_en), 32'd1);
        chk("sim_dstart2", 32'(detect_start), 32'd1);

        // reset while filling with one full buffer
        wr_addr = 15'h0;
        classifier_rd_addr = 15'h0;
        rst = 1'b1;
        tick();
        chk("mr_fill", 32'(fill_level), 32'd0);
        chk("mr_den", 32'(detect_en), 32'd0);
        chk("mr_dstart", 32'(detect_start), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_wren", 32'(mem_wr_en), 32'd0);
        chk("mr_wraddr", 32'(mem_wr_addr), 32'd0);
        chk("mr_rdaddr", 32'(mem_rd_addr), 32'd0);

        // detect_done while idle must not underflow
        rst = 1'b0;
        cont_mode = 1'b0;
        detect_done = 1'b1;
        tick();
        detect_done = 1'b0;
        tick();
        chk("idle_done_fill", 32'(fill_level), 32'd0);
        chk("idle_done_den", 32'(detect_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/detect_buf_sched.md
DETECT_BUF_SCHED -- requirements
Module: detect_buf_sched

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the per-buffer address width.
REQ-002 Parameter NBUF, default 2, legal values 2 or 4, SHALL set the number of frame buffers; BUF_W SHALL be localparam 1 (NBUF=2) or 2 (NBUF=4).
REQ-003 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cap_done  in  1  capture frame-boundary level; a rising edge marks end of one frame and start of the next.
- detect_done  in  1  one-cycle pulse; the classifier finished the current buffer.
- continue  in  1  one-cycle arm request for a single capture.
- cont_mode  in  1  1 = capture every frame without arming.
- write_en_in  in  1  capture pixel write strobe.
- wr_addr  in  ADDR_W  capture write address.
- classifier_rd_addr  in  ADDR_W  classifier read address.
- mem_wr_en  out  1  gated memory write enable.
- mem_wr_addr  out  ADDR_W+BUF_W  {wr_ptr, wr_addr}.
- mem_rd_addr  out  ADDR_W+BUF_W  {rd_ptr, classifier_rd_addr}.
- detect_en  out  1  classifier enable, registered.
- detect_start  out  1  one-cycle pulse at the start of each detection, registered.
- fill_level  out  BUF_W+1  number of full, unconsumed buffers.
- busy  out  1  high when either FSM is non-idle or fill_level is nonzero.
- frames_dropped  out  8  present only under DROP_COUNT_EN.

Function
REQ-004 rise SHALL be cap_done & ~cap_done_z, where cap_done_z is cap_done registered.
REQ-005 Capture FSM states SHALL be C_IDLE, C_SYNC and C_FILL.
REQ-006 In C_IDLE, continue=1 SHALL set arm_latched.
- arm_latched=1 or cont_mode=1 SHALL move to C_SYNC next cycle and clear arm_latched.
REQ-007 In C_SYNC, a rise with fill_level<NBUF SHALL enter C_FILL; a rise with fill_level==NBUF SHALL stay in C_SYNC and count as a dropped frame.
REQ-008 In C_FILL, a rise SHALL:
- mark buffer wr_ptr full (fill_level+1);
- advance wr_ptr modulo NBUF;
- if cont_mode=0, go to C_IDLE;
- if cont_mode=1 and a free buffer remains after this update, stay in C_FILL;
- otherwise go to C_SYNC and count a dropped frame.
REQ-009 mem_wr_en SHALL equal write_en_in when in C_FILL, otherwise 0; it and both address outputs SHALL be combinational.
REQ-010 Detect FSM states SHALL be D_IDLE and D_RUN.
- D_IDLE with fill_level>0 SHALL go to D_RUN, with detect_en<=1 and detect_start<=1 for one cycle.
REQ-011 In D_RUN, detect_done SHALL:
- decrement fill_level;
- advance rd_ptr modulo NBUF;
- clear detect_en;
- return to D_IDLE.
- detect_en therefore stays low at least one cycle between detections.
REQ-012 detect_done in D_IDLE SHALL be ignored; continue outside C_IDLE SHALL be ignored.
REQ-013 Latency: if edge k registers the completing rise, fill_level SHALL update at edge k and detect_en SHALL be high after edge k+1, provided D_IDLE.
REQ-014 A simultaneous increment and decrement of fill_level SHALL leave it unchanged; fill_level SHALL never exceed NBUF nor underflow.
REQ-015 Buffers SHALL be consumed in fill order, so rd_ptr trails wr_ptr in FIFO order.

Reset
REQ-016 rst SHALL clear:
- both FSMs to C_IDLE/D_IDLE;
- wr_ptr, rd_ptr, fill_level, arm_latched, detect_en, detect_start and frames_dropped to 0.
REQ-017 rst SHALL set cap_done_z to 1, so a level-high cap_done after reset is not a rise.
REQ-018 Reset mid-capture or mid-detection SHALL abandon all buffer contents with no further outputs.

Configuration
REQ-019 With DROP_COUNT_EN defined, frames_dropped SHALL increment by 1 per dropped frame (REQ-007, REQ-008) and saturate at 255.
REQ-020 Without DROP_COUNT_EN, the frames_dropped port and its counter SHALL be absent; all other behaviour is identical.

Verification (NBUF=2, ADDR_W=15)
REQ-021 Single shot: continue pulse, then cap_done rises twice with write_en_in=1 between them. Required: mem_wr_addr MSB=0 during fill; fill_level=1; detect_en high one cycle after; return to C_IDLE.
REQ-022 Cont_mode=1, detect_done withheld, three frame rises after sync. Required: buffers 0 and 1 filled; fill_level=2; third frame dropped; frames_dropped=1.
REQ-023 Detect_done pulsed in the same cycle as a completing rise. Required: fill_level unchanged; rd_ptr advances; detect_en low one cycle, then high again with detect_start.
REQ-024 cap_done held high through reset release with cont_mode=1. Required: no fill until the next genuine 0->1 transition.
REQ-025 rst asserted in C_FILL with fill_level=1. Required: all outputs 0 next cycle; mem_wr_en=0 despite write_en_in=1.
